// File: rtl/sr_latch_driver_pkg.sv
// Shared definitions for the SR latch driver: FSM state encoding, pending-request
// bundle and default timing parameters.
package sr_latch_driver_pkg;

  localparam int unsigned DEF_DB_CNT    = 4;
  localparam int unsigned DEF_PULSE_LEN = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    RST_P = 2'd2,
    GAP   = 2'd3
  } drv_state_e;

  // Requests that arrived while a pulse or gap was in progress (depth 1 each).
  typedef struct packed {
    logic s;
    logic r;
  } pend_t;

endpackage

// File: rtl/sr_debounce.sv
// One request channel: two-flop synchronizer, consecutive-sample debounce and a
// single-cycle strobe on each debounced rising edge.
module sr_debounce
  import sr_latch_driver_pkg::*;
#(
  parameter int unsigned DB_CNT = DEF_DB_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic req_o
);

  localparam int unsigned CW = $clog2(DB_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

  logic [1:0]    sync_q;
  logic          synced;
  logic          stable_q;
  logic          stable_d;
  logic          stable_dly_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign synced = sync_q[1];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    stable_d = stable_q;
    cnt_d    = '0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      sync_q       <= {sync_q[0], raw_i};
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign req_o = stable_q & ~stable_dly_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Conditions raw set/reset requests into non-overlapping, fixed-length active-low
// pulses for a NAND SR latch; sbar and rbar are never low together.
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int unsigned DB_CNT    = DEF_DB_CNT,
  parameter int unsigned PULSE_LEN = DEF_PULSE_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_raw,
  input  logic reset_raw,
  output logic sbar,
  output logic rbar,
  output logic busy,
  output logic conflict
);

  localparam int unsigned PCW = $clog2(PULSE_LEN + 1);
  localparam logic [PCW-1:0] PCNT_LAST = PCW'(PULSE_LEN - 1);

  logic set_req;
  logic reset_req;

  drv_state_e     state_q, state_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  pend_t          pend_q, pend_d;
  logic           conflict_d;
  logic           sbar_q, rbar_q, busy_q, conflict_q;

  sr_debounce #(.DB_CNT(DB_CNT)) u_db_set (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (set_raw),
    .req_o (set_req)
  );

  sr_debounce #(.DB_CNT(DB_CNT)) u_db_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (reset_raw),
    .req_o (reset_req)
  );

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    pend_d     = pend_q;
    conflict_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        pcnt_d = '0;
        if (set_req && reset_req) begin
          // Simultaneous requests: reset wins and the set request is dropped.
          state_d    = RST_P;
          pend_d.r   = 1'b0;
          conflict_d = 1'b1;
        end else if (reset_req || pend_q.r) begin
          state_d  = RST_P;
          pend_d.r = 1'b0;
          pend_d.s = pend_q.s | set_req;
        end else if (set_req || pend_q.s) begin
          state_d  = SET_P;
          pend_d.s = 1'b0;
        end
      end
      SET_P, RST_P: begin
        if (pcnt_q == PCNT_LAST) begin
          state_d = GAP;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
        pend_d.s   = pend_q.s | set_req;
        pend_d.r   = pend_q.r | reset_req;
        conflict_d = set_req & reset_req;
      end
      GAP: begin
        state_d    = IDLE;
        pend_d.s   = pend_q.s | set_req;
        pend_d.r   = pend_q.r | reset_req;
        conflict_d = set_req & reset_req;
      end
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      pend_q     <= '0;
      sbar_q     <= 1'b1;
      rbar_q     <= 1'b1;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      pend_q     <= pend_d;
      sbar_q     <= (state_d != SET_P);
      rbar_q     <= (state_d != RST_P);
      busy_q     <= (state_d != IDLE);
      conflict_q <= conflict_d;
    end
  end

  assign sbar     = sbar_q;
  assign rbar     = rbar_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver: a request-level reference model queues the
// expected pulses and conflicts; an independent monitor matches what the DUT drives.
`timescale 1ns/1ps
module tb_sr_latch_driver;

  localparam int DB_CNT    = 4;
  localparam int PULSE_LEN = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic set_raw = 1'b0;
  logic reset_raw = 1'b0;
  logic sbar, rbar, busy, conflict;

  sr_latch_driver #(.DB_CNT(DB_CNT), .PULSE_LEN(PULSE_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_raw   (set_raw),
    .reset_raw (reset_raw),
    .sbar      (sbar),
    .rbar      (rbar),
    .busy      (busy),
    .conflict  (conflict)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int e     = 0;  // clock edges since reset release

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, actual, expected, e);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic is_rst;
    int   edge_no;
  } pulse_t;

  pulse_t exp_pulses[$];
  int     exp_conf[$];

  bit d1[2], d2[2], st[2];
  bit hist[2][DB_CNT];
  int hcnt[2];
  bit req_s, req_r, pend_s, pend_r;
  int free_edge, busy_start;
  bit busy_valid, exp_busy;

  // Debounced value flips once the last DB_CNT synchronized samples all disagree
  // with it; returns 1 on the edge where it becomes 1.
  function automatic bit db_edge(input int ch, input bit raw);
    bit syn;
    bit all_diff;
    syn    = d2[ch];
    d2[ch] = d1[ch];
    d1[ch] = raw;
    for (int k = DB_CNT - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = syn;
    if (hcnt[ch] < DB_CNT) hcnt[ch]++;
    all_diff = (hcnt[ch] == DB_CNT);
    for (int k = 0; k < DB_CNT; k++) if (hist[ch][k] == st[ch]) all_diff = 1'b0;
    if (!all_diff) return 1'b0;
    st[ch] = ~st[ch];
    return st[ch];
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      d1[c] = 0; d2[c] = 0; st[c] = 0; hcnt[c] = 0;
      for (int k = 0; k < DB_CNT; k++) hist[c][k] = 0;
    end
    req_s = 0; req_r = 0; pend_s = 0; pend_r = 0;
    free_edge = 0; busy_start = 0; busy_valid = 0; exp_busy = 0;
    e = 0;
    exp_pulses.delete();
    exp_conf.delete();
  endfunction

  function automatic void start_pulse(input bit is_rst);
    exp_pulses.push_back('{is_rst: is_rst, edge_no: e});
    busy_start = e;
    busy_valid = 1;
    free_edge  = e + PULSE_LEN + 2;  // pulse, one gap cycle, then idle decides again
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit s, r;
    if (!rst_n) begin
      model_reset();
    end else begin
      e++;
      s = req_s;
      r = req_r;
      if (e >= free_edge) begin
        if (r || pend_r) begin
          start_pulse(1);
          pend_r = 0;
          if (s && !r) pend_s = 1;
        end else if (s || pend_s) begin
          start_pulse(0);
          pend_s = 0;
        end
      end else begin
        pend_s |= s;
        pend_r |= r;
      end
      if (s && r) exp_conf.push_back(e);
      exp_busy = busy_valid && (e >= busy_start) && (e <= busy_start + PULSE_LEN);
      req_s = db_edge(0, set_raw);
      req_r = db_edge(1, reset_raw);
    end
  end

  // ---------------- monitor ----------------
  bit ps = 1, pr = 1;
  int s_low = 0, r_low = 0;
  int n_s = 0, n_r = 0, n_conf = 0;
  int last_s_start = -1, last_r_start = -1;
  bit latch_q = 0;

  always @(negedge clk) begin
    pulse_t p;
    if (!rst_n) begin
      check("reset_outputs", {28'd0, sbar, rbar, busy, conflict}, 32'b1100);
      ps = 1; pr = 1; s_low = 0; r_low = 0;
    end else begin
      check("never_both_low", sbar | rbar, 1);
      check("busy", busy, exp_busy);
      if (!sbar) latch_q = 1;
      else if (!rbar) latch_q = 0;

      if (ps && !sbar) begin
        n_s++; last_s_start = e; s_low = 0;
        check("set_pulse_expected", exp_pulses.size() > 0, 1);
        if (exp_pulses.size() > 0) begin
          p = exp_pulses.pop_front();
          check("set_pulse_kind_is_rst", p.is_rst, 0);
          check("set_pulse_edge", e, p.edge_no);
        end
      end
      if (pr && !rbar) begin
        n_r++; last_r_start = e; r_low = 0;
        check("rst_pulse_expected", exp_pulses.size() > 0, 1);
        if (exp_pulses.size() > 0) begin
          p = exp_pulses.pop_front();
          check("rst_pulse_kind_is_rst", p.is_rst, 1);
          check("rst_pulse_edge", e, p.edge_no);
        end
      end
      if (!sbar) s_low++;
      if (!rbar) r_low++;
      if (!ps && sbar) check("sbar_width", s_low, PULSE_LEN);
      if (!pr && rbar) check("rbar_width", r_low, PULSE_LEN);
      ps = sbar;
      pr = rbar;

      if (exp_pulses.size() > 0 && exp_pulses[0].edge_no < e) begin
        p = exp_pulses.pop_front();
        check("pulse_missing_at_edge", e, p.edge_no);
      end

      if (conflict) begin
        n_conf++;
        check("conflict_expected", exp_conf.size() > 0, 1);
        if (exp_conf.size() > 0) check("conflict_edge", e, exp_conf.pop_front());
      end
      if (exp_conf.size() > 0 && exp_conf[0] < e) check("conflict_missing_at_edge", e, exp_conf.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int e0, s0, r0, c0;
    bit found;

    // Reset with random inputs, then idle.
    #1 rst_n = 1'b0;
    repeat (5) begin
      tick(1);
      set_raw   = 1'($urandom);
      reset_raw = 1'($urandom);
    end
    tick(1);
    set_raw = 0; reset_raw = 0; rst_n = 1'b1;
    tick(20);
    check("idle_no_pulses", n_s + n_r, 0);
    check("idle_sbar", sbar, 1);

    // Clean set.
    e0 = e + 1; s0 = n_s; r0 = n_r;
    set_raw = 1; tick(10); set_raw = 0; tick(20);
    check("clean_set_count", n_s - s0, 1);
    check("clean_set_no_rst", n_r - r0, 0);
    check("clean_set_start", last_s_start, e0 + DB_CNT + 2);
    check("latch_q_after_set", latch_q, 1);

    // Glitch reject, then accepted request.
    r0 = n_r;
    reset_raw = 1; tick(3); reset_raw = 0; tick(20);
    check("glitch_rejected", n_r - r0, 0);
    reset_raw = 1; tick(4); reset_raw = 0; tick(20);
    check("long_rst_accepted", n_r - r0, 1);
    check("latch_q_after_rst", latch_q, 0);

    // Simultaneous.
    s0 = n_s; r0 = n_r; c0 = n_conf;
    set_raw = 1; reset_raw = 1; tick(10); set_raw = 0; reset_raw = 0; tick(20);
    check("simul_rst_count", n_r - r0, 1);
    check("simul_set_dropped", n_s - s0, 0);
    check("simul_conflict_count", n_conf - c0, 1);

    // Reset request arriving during a set pulse is served after it.
    s0 = n_s; r0 = n_r;
    set_raw = 1; tick(1); reset_raw = 1; tick(10); set_raw = 0; reset_raw = 0; tick(30);
    check("pending_set_count", n_s - s0, 1);
    check("pending_rst_count", n_r - r0, 1);
    check("pending_spacing", last_r_start - last_s_start, PULSE_LEN + 2);

    // Asynchronous abort in the middle of a set pulse.
    s0 = n_s;
    found = 0;
    set_raw = 1;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1);
      if (!sbar) found = 1;
    end
    check("abort_reached_set_pulse", found, 1);
    set_raw = 0;
    #1 rst_n = 1'b0;
    #1;
    check("abort_sbar_released", sbar, 1);
    check("abort_busy_cleared", busy, 0);
    tick(3);
    rst_n = 1'b1;
    s0 = n_s;
    tick(20);
    check("abort_no_pulse_after", n_s - s0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      tick(1);
      if ($urandom_range(5) == 0) set_raw = ~set_raw;
      if ($urandom_range(5) == 0) reset_raw = ~reset_raw;
      if ($urandom_range(40) == 0) begin
        set_raw = 1; reset_raw = 1;
      end
    end
    set_raw = 0; reset_raw = 0;
    tick(40);
    check("drain_pulses", exp_pulses.size(), 0);
    check("drain_conflicts", exp_conf.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
